// File: rtl/apb_master_param.sv
// ---------------------------------------------------------------------------
// apb_master_param
//
// APB3 bridge master. It turns a single-request CPU bus transaction into an
// APB SETUP/ACCESS transfer to one of NUM_SLV peripheral slots. The slots sit
// in a contiguous window that starts at BASE_ADDR, and each slot spans
// 2**SLOT_BITS bytes.
//
// An access to an address outside the window is not forwarded. It completes
// with error = 1 and rdata = 0. A slave's PSLVERR is returned on the error
// output. The response outputs ready, error and rdata are registered.
//
// Optional feature (compile-time macro): APB_MASTER_TIMEOUT_EN
//    When defined, an ACCESS phase that waits TIMEOUT_CYC cycles without
//    PREADY is abandoned. It completes with error = 1 and rdata = 0.
//    When undefined, ACCESS waits for PREADY indefinitely.
//
// Ports
//    PCLK      in   clock
//    PRESET    in   asynchronous active-high reset
//    PADDR     out  latched transfer address
//    PWRITE    out  latched direction (1 = write)
//    PWDATA    out  latched write data
//    PENABLE   out  ACCESS phase indicator
//    PSEL      out  one-hot slave select, NUM_SLV bits
//    PRDATA    in   flattened read data, slave i at [i*DATA_W +: DATA_W]
//    PREADY    in   per-slave ready
//    PSLVERR   in   per-slave error
//    transfer  in   request strobe, only looked at while idle
//    write     in   request direction
//    addr      in   request address
//    wdata     in   request write data
//    ready     out  one-cycle completion pulse
//    rdata     out  read data, held until the next completion
//    error     out  completion status, valid with ready
// ---------------------------------------------------------------------------
module apb_master_param #(
   parameter int                NUM_SLV     = 8,
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
   parameter int                SLOT_BITS   = 12,
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   output logic [ADDR_W-1:0]         PADDR,
   output logic                      PWRITE,
   output logic [DATA_W-1:0]         PWDATA,
   output logic                      PENABLE,
   output logic [NUM_SLV-1:0]        PSEL,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR,
   input  logic                      transfer,
   input  logic                      write,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic                      ready,
   output logic [DATA_W-1:0]         rdata,
   output logic                      error
);

   localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apbState_e;

   // Reject configurations the slot decode and the timeout counter cannot
   // represent, so that a bad instantiation fails at elaboration.
   if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_paramCheck
      $error("apb_master_param: NUM_SLV must be 1..16 and TIMEOUT_CYC 1..65535");
   end

   apbState_e           state_q, state_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [IDX_W-1:0]    slotIdx_q, slotIdx_d;
   logic                mapped_q, mapped_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC < 256) ? 8 : 16;
   logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
`endif

   logic [ADDR_W-1:0]   reqOffset;
   logic [ADDR_W-1:0]   reqSlot;
   logic                reqMapped;
   logic [IDX_W-1:0]    reqIdx;

   logic                selReady;
   logic                selErr;
   logic [DATA_W-1:0]   selRdata;
   logic [NUM_SLV-1:0]  selOneHot;

   // Slot decode of the incoming request. The full shifted offset is compared
   // against NUM_SLV so that addresses above the window are caught. The
   // narrow index kept in the latch is only used when the address is mapped.
   assign reqOffset = addr - BASE_ADDR;
   assign reqSlot   = reqOffset >> SLOT_BITS;
   assign reqMapped = (addr >= BASE_ADDR) && (reqSlot < ADDR_W'(NUM_SLV));
   assign reqIdx    = reqSlot[IDX_W-1:0];

   // Pick out the selected slave's response signals with an equality loop
   // rather than a variable index. Unselected slaves never reach the result,
   // even if they drive X. A slot count that is not a power of two also
   // cannot index past the end of the vectors.
   always_comb begin
      selReady  = 1'b0;
      selErr    = 1'b0;
      selRdata  = '0;
      selOneHot = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (slotIdx_q == IDX_W'(i)) begin
            selReady     = PREADY[i];
            selErr       = PSLVERR[i];
            selRdata     = PRDATA[i*DATA_W +: DATA_W];
            selOneHot[i] = 1'b1;
         end
      end
   end

   // The APB strobes come straight from the state register. A reset therefore
   // drops PSEL and PENABLE as soon as it is asserted, without waiting for a
   // clock edge. An unmapped transfer still walks through SETUP and ACCESS
   // but never selects a slave.
   always_comb begin
      PSEL    = '0;
      PENABLE = 1'b0;
      if ((state_q == SETUP || state_q == ACCESS) && mapped_q) begin
         PSEL = selOneHot;
      end
      if (state_q == ACCESS && mapped_q) begin
         PENABLE = 1'b1;
      end
   end

   assign PADDR  = paddr_q;
   assign PWRITE = pwrite_q;
   assign PWDATA = pwdata_q;
   assign ready  = ready_q;
   assign error  = error_q;
   assign rdata  = rdata_q;

   // Next-state logic. Every register holds its value by default.
   // The request latches load only in IDLE, which keeps the APB address
   // and data stable for the whole transfer. It also means a strobe seen
   // in any other state is dropped rather than queued. ready_d is set on
   // exactly the transition into RESP, so the registered pulse lines up
   // with the RESP cycle.
   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      slotIdx_d = slotIdx_q;
      mapped_d  = mapped_q;
      ready_d   = 1'b0;
      error_d   = error_q;
      rdata_d   = rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
      waitCnt_d = waitCnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (transfer) begin
               paddr_d   = addr;
               pwrite_d  = write;
               pwdata_d  = wdata;
               slotIdx_d = reqIdx;
               mapped_d  = reqMapped;
               state_d   = SETUP;
            end
         end

         SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
            waitCnt_d = '0;
`endif
            state_d = ACCESS;
         end

         ACCESS: begin
            if (!mapped_q) begin
               error_d = 1'b1;
               rdata_d = '0;
               ready_d = 1'b1;
               state_d = RESP;
            end else if (selReady) begin
               error_d = selErr;
               if (!pwrite_q) begin
                  rdata_d = selRdata;
               end
               ready_d = 1'b1;
               state_d = RESP;
            end else begin
`ifdef APB_MASTER_TIMEOUT_EN
               waitCnt_d = waitCnt_q + 1'b1;
               if (waitCnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  error_d = 1'b1;
                  rdata_d = '0;
                  ready_d = 1'b1;
                  state_d = RESP;
               end
`else
               state_d = ACCESS;
`endif
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. The reset is asynchronous, so an
   // in-flight transfer is abandoned as soon as reset is asserted and no
   // completion pulse follows.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         slotIdx_q <= '0;
         mapped_q  <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         rdata_q   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         waitCnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         slotIdx_q <= slotIdx_d;
         mapped_q  <= mapped_d;
         ready_q   <= ready_d;
         error_q   <= error_d;
         rdata_q   <= rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
         waitCnt_q <= waitCnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_apb_master_param.sv
// ---------------------------------------------------------------------------
// tb_apb_master_param
//
// Directed testbench for apb_master_param with 8 slots of 32-bit data.
// The bench is built with TIMEOUT_CYC = 4 when APB_MASTER_TIMEOUT_EN is
// defined. Inputs change 1 time unit after the rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_apb_master_param;

   localparam int NS = 8;
   localparam int DW = 32;
   localparam int AW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic              PCLK;
   logic              PRESET;
   logic [AW-1:0]     PADDR;
   logic              PWRITE;
   logic [DW-1:0]     PWDATA;
   logic              PENABLE;
   logic [NS-1:0]     PSEL;
   logic [NS*DW-1:0]  PRDATA;
   logic [NS-1:0]     PREADY;
   logic [NS-1:0]     PSLVERR;
   logic              transfer;
   logic              write;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     wdata;
   logic              ready;
   logic [DW-1:0]     rdata;
   logic              error;

   int checks   = 0;
   int errCount = 0;

   apb_master_param #(
      .NUM_SLV     (NS),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .BASE_ADDR   (32'h1000_0000),
      .SLOT_BITS   (12),
      .TIMEOUT_CYC (TO)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PWDATA   (PWDATA),
      .PENABLE  (PENABLE),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .rdata    (rdata),
      .error    (error)
   );

   // 10-unit clock
   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Present a request on the CPU side
   task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      transfer = 1'b1;
      write    = wr;
      addr     = a;
      wdata    = d;
   endtask

   task automatic test_reset();
      PRESET   = 1'b1;
      transfer = 1'b0;
      write    = 1'b0;
      addr     = '0;
      wdata    = '0;
      PREADY   = '0;
      PSLVERR  = '0;
      PRDATA   = '0;
      tick();
      tick();
      checks++;
      if ({PSEL, PENABLE, PWRITE, ready, error} !== 12'h000) begin
         errCount++;
         $display("[TB] FAIL reset_ctrl: got %b expected %b", {PSEL, PENABLE, PWRITE, ready, error}, 12'h000);
      end
      checks++;
      if ({PADDR, PWDATA, rdata} !== 96'h0) begin
         errCount++;
         $display("[TB] FAIL reset_data: got %h expected %h", {PADDR, PWDATA, rdata}, 96'h0);
      end
      PRESET = 1'b0;
      tick();
   endtask

   task automatic test_write_zero_wait();
      PREADY  = 8'b0000_0100;
      PSLVERR = '0;
      applyStimulus(1'b1, 32'h1000_2004, 32'hDEAD_BEEF);
      tick();
      transfer = 1'b0;
      addr     = 32'h1000_5000;
      wdata    = 32'h0;
      checks++;
      if ({PSEL, PENABLE, PWRITE, ready} !== {8'b0000_0100, 1'b0, 1'b1, 1'b0}) begin
         errCount++;
         $display("[TB] FAIL wr_setup_ctrl: got %b expected %b", {PSEL, PENABLE, PWRITE, ready}, {8'b0000_0100, 1'b0, 1'b1, 1'b0});
      end
      checks++;
      if ({PADDR, PWDATA} !== {32'h1000_2004, 32'hDEAD_BEEF}) begin
         errCount++;
         $display("[TB] FAIL wr_setup_data: got %h expected %h", {PADDR, PWDATA}, {32'h1000_2004, 32'hDEAD_BEEF});
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, ready, PADDR, PWDATA} !== {8'b0000_0100, 1'b1, 1'b0, 32'h1000_2004, 32'hDEAD_BEEF}) begin
         errCount++;
         $display("[TB] FAIL wr_access: got %h expected %h", {PSEL, PENABLE, ready, PADDR, PWDATA}, {8'b0000_0100, 1'b1, 1'b0, 32'h1000_2004, 32'hDEAD_BEEF});
      end
      tick();
      checks++;
      if ({ready, error, PSEL, PENABLE} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         errCount++;
         $display("[TB] FAIL wr_resp: got %b expected %b", {ready, error, PSEL, PENABLE}, {1'b1, 1'b0, 8'h00, 1'b0});
      end
      tick();
      checks++;
      if ({ready, PADDR} !== {1'b0, 32'h1000_2004}) begin
         errCount++;
         $display("[TB] FAIL wr_idle_hold: got %h expected %h", {ready, PADDR}, {1'b0, 32'h1000_2004});
      end
   endtask

   task automatic test_read_wait();
      PRDATA                = 'x;
      PRDATA[7*DW +: DW]    = 32'h1234_5678;
      PREADY                = {1'b0, 7'bxxx_xxxx};
      PSLVERR               = {1'b0, 7'bxxx_xxxx};
      applyStimulus(1'b0, 32'h1000_7000, 32'h0);
      tick();
      transfer = 1'b0;
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== {8'h80, 1'b0, 1'b0}) begin
         errCount++;
         $display("[TB] FAIL rd_setup: got %b expected %b", {PSEL, PENABLE, PWRITE}, {8'h80, 1'b0, 1'b0});
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({PSEL, PENABLE, ready} !== {8'h80, 1'b1, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL rd_access_%0d: got %b expected %b", k, {PSEL, PENABLE, ready}, {8'h80, 1'b1, 1'b0});
         end
         if (k == 3) PREADY[7] = 1'b1;
         tick();
      end
      checks++;
      if ({ready, error, PENABLE, rdata} !== {1'b1, 1'b0, 1'b0, 32'h1234_5678}) begin
         errCount++;
         $display("[TB] FAIL rd_resp: got %h expected %h", {ready, error, PENABLE, rdata}, {1'b1, 1'b0, 1'b0, 32'h1234_5678});
      end
      PREADY[7]          = 1'b0;
      PRDATA[7*DW +: DW] = 32'hFFFF_0000;
      tick();
      checks++;
      if ({ready, rdata} !== {1'b0, 32'h1234_5678}) begin
         errCount++;
         $display("[TB] FAIL rd_hold: got %h expected %h", {ready, rdata}, {1'b0, 32'h1234_5678});
      end
   endtask

   task automatic test_unmapped();
      logic [AW-1:0] badAddr [2];
      badAddr[0] = 32'h1000_8000;
      badAddr[1] = 32'h0FFF_FFFC;
      PREADY  = '1;
      PSLVERR = '0;
      PRDATA  = {NS{32'hA5A5_A5A5}};
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, badAddr[i], 32'h0);
         tick();
         transfer = 1'b0;
         checks++;
         if ({PSEL, PENABLE, ready} !== {8'h00, 1'b0, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL unmap%0d_setup: got %b expected %b", i, {PSEL, PENABLE, ready}, {8'h00, 1'b0, 1'b0});
         end
         tick();
         checks++;
         if ({PSEL, PENABLE, ready} !== {8'h00, 1'b0, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL unmap%0d_access: got %b expected %b", i, {PSEL, PENABLE, ready}, {8'h00, 1'b0, 1'b0});
         end
         tick();
         checks++;
         if ({ready, error, PSEL, rdata} !== {1'b1, 1'b1, 8'h00, 32'h0}) begin
            errCount++;
            $display("[TB] FAIL unmap%0d_resp: got %h expected %h", i, {ready, error, PSEL, rdata}, {1'b1, 1'b1, 8'h00, 32'h0});
         end
         tick();
      end
   endtask

   task automatic test_slave_error();
      PRDATA             = '0;
      PRDATA[4*DW +: DW] = 32'hCAFE_0004;
      PREADY             = 8'b0001_0000;
      PSLVERR            = 8'b0001_0000;
      applyStimulus(1'b0, 32'h1000_4010, 32'h0);
      tick();
      transfer = 1'b0;
      tick();
      tick();
      checks++;
      if ({ready, error, rdata} !== {1'b1, 1'b1, 32'hCAFE_0004}) begin
         errCount++;
         $display("[TB] FAIL slverr_resp: got %h expected %h", {ready, error, rdata}, {1'b1, 1'b1, 32'hCAFE_0004});
      end
      tick();
      PREADY             = 8'hFF;
      PSLVERR            = 8'hFE;
      PRDATA[0 +: DW]    = 32'h0000_00A5;
      applyStimulus(1'b0, 32'h1000_0FFC, 32'h0);
      tick();
      transfer = 1'b0;
      checks++;
      if (PSEL !== 8'h01) begin
         errCount++;
         $display("[TB] FAIL slot0_setup: got %b expected %b", PSEL, 8'h01);
      end
      tick();
      tick();
      checks++;
      if ({ready, error, rdata} !== {1'b1, 1'b0, 32'h0000_00A5}) begin
         errCount++;
         $display("[TB] FAIL slot0_isolate: got %h expected %h", {ready, error, rdata}, {1'b1, 1'b0, 32'h0000_00A5});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] expReady;
      expReady = 8'b0100_0100;
      PREADY   = '1;
      PSLVERR  = '0;
      applyStimulus(1'b1, 32'h1000_1000, 32'h0000_0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (ready !== expReady[k]) begin
            errCount++;
            $display("[TB] FAIL b2b_ready_%0d: got %b expected %b", k, ready, expReady[k]);
         end
         if (k == 1) wdata = 32'h0000_0002;
         if (k == 2) begin
            checks++;
            if (PWDATA !== 32'h0000_0001) begin
               errCount++;
               $display("[TB] FAIL b2b_hold: got %h expected %h", PWDATA, 32'h0000_0001);
            end
         end
         if (k == 5) begin
            checks++;
            if (PWDATA !== 32'h0000_0002) begin
               errCount++;
               $display("[TB] FAIL b2b_relatch: got %h expected %h", PWDATA, 32'h0000_0002);
            end
         end
      end
      transfer = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      int pulses;
      PREADY = '0;
      applyStimulus(1'b0, 32'h1000_3000, 32'h0);
      tick();
      transfer = 1'b0;
      tick();
      checks++;
      if ({PSEL, PENABLE} !== {8'h08, 1'b1}) begin
         errCount++;
         $display("[TB] FAIL rst_pre: got %b expected %b", {PSEL, PENABLE}, {8'h08, 1'b1});
      end
      #2;
      PRESET = 1'b1;
      #1;
      checks++;
      if ({PSEL, PENABLE, ready, PADDR} !== {8'h00, 1'b0, 1'b0, 32'h0}) begin
         errCount++;
         $display("[TB] FAIL rst_async: got %h expected %h", {PSEL, PENABLE, ready, PADDR}, {8'h00, 1'b0, 1'b0, 32'h0});
      end
      PREADY = '1;
      tick();
      tick();
      PRESET = 1'b0;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ready !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errCount++;
         $display("[TB] FAIL rst_no_pulse: got %0d expected %0d", pulses, 0);
      end
      applyStimulus(1'b1, 32'h1000_3008, 32'h0BAD_F00D);
      tick();
      transfer = 1'b0;
      checks++;
      if ({PSEL, PWDATA} !== {8'h08, 32'h0BAD_F00D}) begin
         errCount++;
         $display("[TB] FAIL rst_after_setup: got %h expected %h", {PSEL, PWDATA}, {8'h08, 32'h0BAD_F00D});
      end
      tick();
      tick();
      checks++;
      if ({ready, error} !== 2'b10) begin
         errCount++;
         $display("[TB] FAIL rst_after_resp: got %b expected %b", {ready, error}, 2'b10);
      end
      tick();
   endtask

   task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
      PREADY             = '0;
      PSLVERR            = '0;
      PRDATA[5*DW +: DW] = 32'h5555_AAAA;
      applyStimulus(1'b0, 32'h1000_5000, 32'h0);
      tick();
      transfer = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({PSEL, PENABLE, ready} !== {8'h20, 1'b1, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL late_ready_access_%0d: got %b expected %b", k, {PSEL, PENABLE, ready}, {8'h20, 1'b1, 1'b0});
         end
         if (k == 3) PREADY[5] = 1'b1;
      end
      tick();
      checks++;
      if ({ready, error, rdata} !== {1'b1, 1'b0, 32'h5555_AAAA}) begin
         errCount++;
         $display("[TB] FAIL late_ready_wins: got %h expected %h", {ready, error, rdata}, {1'b1, 1'b0, 32'h5555_AAAA});
      end
      PREADY = '0;
      tick();
      applyStimulus(1'b0, 32'h1000_5000, 32'h0);
      tick();
      transfer = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({PSEL, PENABLE, ready} !== {8'h20, 1'b1, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL timeout_access_%0d: got %b expected %b", k, {PSEL, PENABLE, ready}, {8'h20, 1'b1, 1'b0});
         end
      end
      tick();
      checks++;
      if ({ready, error, PSEL, PENABLE, rdata} !== {1'b1, 1'b1, 8'h00, 1'b0, 32'h0}) begin
         errCount++;
         $display("[TB] FAIL timeout_resp: got %h expected %h", {ready, error, PSEL, PENABLE, rdata}, {1'b1, 1'b1, 8'h00, 1'b0, 32'h0});
      end
      tick();
`else
      int pulses;
      PREADY  = '0;
      PSLVERR = '0;
      applyStimulus(1'b0, 32'h1000_5000, 32'h0);
      tick();
      transfer = 1'b0;
      tick();
      pulses = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (ready !== 1'b0) pulses++;
      end
      checks++;
      if ({pulses, PSEL, PENABLE} !== {32'd0, 8'h20, 1'b1}) begin
         errCount++;
         $display("[TB] FAIL no_timeout_hold: got %h expected %h", {pulses, PSEL, PENABLE}, {32'd0, 8'h20, 1'b1});
      end
      PREADY[5] = 1'b1;
      tick();
      checks++;
      if ({ready, error} !== 2'b10) begin
         errCount++;
         $display("[TB] FAIL no_timeout_release: got %b expected %b", {ready, error}, 2'b10);
      end
      PREADY = '0;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_unmapped();
      test_slave_error();
      test_back_to_back();
      test_reset_mid_access();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errCount);
      $finish;
   end

endmodule
